store_buffer: RTL



---
 rtl/store_buffer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// Posted-write store buffer between the MEM stage and a combinational byte-addressed data memory.
// Loads own the port; queued stores retire in idle port cycles, with forwarding or stalling on overlap.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpuAddress,
  input  logic [DATA_W-1:0] cpuWriteData,
  input  logic              cpuWrite,
  input  logic              cpuRead,
  input  logic              cpuDataSize,
  input  logic              cpuFlush,
  output logic [DATA_W-1:0] cpuReadData,
  output logic              stall,
  output logic              bufEmpty,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] writeData,
  output logic              memoryWrite,
  output logic              memoryRead,
  output logic              memDataSize,
  input  logic [DATA_W-1:0] readData
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              size;
  } entry_t;

  entry_t           entry_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;

  logic              hit_any, hit_exact;
  logic [DATA_W-1:0] hit_data;
  logic [ADDR_W:0]   ld_lo, ld_hi, en_lo, en_hi;
  logic [PTR_W-1:0]  idx;

  logic flush_stall, rd_stall, full_stall, drain, enq, fwd, mem_rd;

  // Byte-range overlap against every live entry, scanned oldest to youngest so the youngest hit wins.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves one unassigned (no latches).
    hit_any   = 1'b0;
    hit_exact = 1'b0;
    hit_data  = '0;
    idx       = '0;
    en_lo     = '0;
    en_hi     = '0;
    ld_lo     = {1'b0, cpuAddress};
    ld_hi     = ld_lo + (cpuDataSize ? (ADDR_W+1)'(0) : (ADDR_W+1)'(3));
    for (int k = 0; k < DEPTH; k++) begin
      idx   = head_q + PTR_W'(k);
      en_lo = {1'b0, entry_q[idx].addr};
      en_hi = en_lo + (entry_q[idx].size ? (ADDR_W+1)'(0) : (ADDR_W+1)'(3));
      if ((CNT_W'(k) < count_q) && (en_lo <= ld_hi) && (ld_lo <= en_hi)) begin
        hit_any   = 1'b1;
        hit_exact = (entry_q[idx].addr == cpuAddress) && (entry_q[idx].size == cpuDataSize);
        hit_data  = entry_q[idx].data;
      end
    end
  end

  always_comb begin
    bufEmpty    = (count_q == '0);
    flush_stall = cpuFlush & ~bufEmpty;
    rd_stall    = cpuRead & hit_any & ~hit_exact;
    full_stall  = cpuWrite & ~cpuRead & full_q;
    stall       = flush_stall | rd_stall | full_stall;
    // An overlapping load forces the head out even though it owns the port this cycle.
    drain       = ~bufEmpty & (flush_stall | rd_stall | (~cpuRead & (~cpuWrite | full_q)));
    enq         = cpuWrite & ~cpuRead & ~full_q & ~flush_stall;
    fwd         = cpuRead & hit_any & hit_exact & ~flush_stall;
    mem_rd      = cpuRead & ~hit_any & ~flush_stall;

    address     = '0;
    writeData   = '0;
    memoryWrite = 1'b0;
    memoryRead  = 1'b0;
    memDataSize = 1'b0;
    cpuReadData = '0;
    if (drain) begin
      memoryWrite = 1'b1;
      address     = entry_q[head_q].addr;
      writeData   = entry_q[head_q].data;
      memDataSize = entry_q[head_q].size;
    end else if (mem_rd) begin
      memoryRead  = 1'b1;
      address     = cpuAddress;
      memDataSize = cpuDataSize;
      cpuReadData = readData;
    end
    if (fwd) begin
      cpuReadData = hit_data;
      if (cpuDataSize) cpuReadData = {{(DATA_W-8){1'b0}}, hit_data[7:0]};
    end

    head_d  = head_q + PTR_W'(drain);
    tail_d  = tail_q + PTR_W'(enq);
    count_d = count_q + CNT_W'(enq) - CNT_W'(drain);
    full_d  = (count_d == CNT_W'(DEPTH));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; count_q gates validity, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (enq) entry_q[tail_q] <= '{addr: cpuAddress, data: cpuWriteData, size: cpuDataSize};
  end

endmodule
